vjtag_readback_tx: RTL and testbench
====================================

VJTAG_READBACK_TX -- requirements
Module: vjtag_readback_tx

Interface
REQ-001 Parameter DW, default 32: readback word width and data-register scan length.
REQ-002 Parameter DEPTH, default 4: pending-word FIFO depth; power of two, 2..16.
REQ-003 CLK  in  1: single clock, driven by the virtual-JTAG tck; all state updates on its rising edge.
REQ-004 aclr_n  in  1: reset, asynchronous, active-low.
REQ-005 ir_in  in  2: virtual instruction; 2'b11 DATA, 2'b01 STATUS, any other value BYPASS.
REQ-006 vs_cdr, vs_sdr, vs_udr  in  1 each: Capture-DR, Shift-DR and Update-DR state strobes, one cycle each per scan.
REQ-007 tdi  in  1: serial data from the host.
REQ-008 tdo  out  1: serial data to the host.
REQ-009 wr_valid  in  1, wr_data  in  DW, wr_ready  out  1: fabric-side push handshake for words queued to the host.
REQ-010 fifo_count  out  $clog2(DEPTH)+1: current FIFO occupancy.

Function
REQ-011 Push SHALL occur on a cycle with wr_valid=1 and wr_ready=1; wr_ready=1 exactly when fifo_count<DEPTH, regardless of any same-cycle pop.
REQ-012 When wr_valid=1 and wr_ready=0, the sticky ovf flag SHALL set and the word SHALL be dropped.
REQ-013 On vs_cdr with DATA: sr<=FIFO head if count>0 and cap_valid<=1; else sr<=0, cap_valid<=0, and the sticky udf flag SHALL set.
REQ-014 On vs_cdr with STATUS: sr<={8'hA5, 16'h0, ovf, udf, 3'b0, count}, with count zero-extended or truncated to 3 bits for DEPTH>4 (fifo_count remains authoritative); cap_valid<=0.
REQ-015 On vs_cdr with BYPASS: the 1-bit bypass register SHALL be loaded with 0.
REQ-016 Every vs_cdr SHALL clear the shift counter; each vs_sdr cycle SHALL increment it, saturating at DW.
REQ-017 On vs_sdr with DATA or STATUS: sr<={tdi, sr[DW-1:1]} (LSB first); on vs_sdr with BYPASS: bypass<=tdi.
REQ-018 tdo SHALL be combinational: sr[0] when ir_in selects DATA or STATUS, the bypass bit otherwise.
REQ-019 On vs_udr with DATA, cap_valid=1 and counter=DW: the FIFO head SHALL be popped and cap_valid cleared; a short scan (counter<DW) SHALL NOT pop, so the word is re-offered at the next capture.
REQ-020 On vs_udr with STATUS and counter=DW: ovf and udf SHALL clear, except that an overflow in that same cycle SHALL leave ovf set.
REQ-021 A push and a pop in the same cycle SHALL leave the count unchanged and keep FIFO order intact.
REQ-022 FIFO read and write pointers SHALL wrap modulo DEPTH; the count SHALL never exceed DEPTH or underflow below 0.
REQ-023 A change of ir_in between capture and update SHALL cancel any pending pop (cap_valid cleared on any IR change).

Reset
REQ-024 While aclr_n=0, the block SHALL hold: FIFO empty (pointers and count 0), wr_ready=1, sr=0, bypass=0, shift counter=0, cap_valid=0, ovf=0, udf=0, and tdo=0.
REQ-025 Asserting reset mid-scan SHALL discard the scan and any queued words; the block SHALL NOT pop or raise flags on release.

Structure
REQ-026 A shared package SHALL hold the IR encodings (DATA, STATUS), the status signature 8'hA5, and the status field bit positions, all of which are shared with the command-receive block.
REQ-027 The FIFO SHALL be one sub-module, readback_fifo (parameters DW and DEPTH; push/pop/count ports); the scan logic and flags stay at top level.

Verification
REQ-028 Reset, then push 32'hDEADBEEF, then run a DATA scan of 32 bits -> tdo stream LSB-first equals DEADBEEF, the pop occurs at update, and fifo_count goes 1->0.
REQ-029 Push 5 words with DEPTH=4 -> wr_ready=0 after the 4th push, the 5th word is dropped, and a STATUS scan returns 32'hA5000084.
REQ-030 Run a DATA scan with the FIFO empty -> 32 zeros are shifted out, udf is set, and a subsequent full STATUS scan reads the udf bit =1 then clears it (the next status read is 32'hA5000000).
REQ-031 With 2 words queued, run a 16-bit DATA scan then a full scan -> the first word appears again in the full scan, and only that full scan pops it.
REQ-032 With a full FIFO, push and pop in the same cycle -> the pop is accepted, the push is refused (wr_ready=0), ovf is set, and the count is 3.
REQ-033 Drop aclr_n during a DATA scan at bit 10 -> all outputs reach their reset values immediately, and no pop occurs after release.

Source files
------------

// File: rtl/vjtag_readback_tx_pkg.sv
// Shared virtual-JTAG readback definitions: IR encodings, status signature and
// status-word field layout, common to the readback and command-receive blocks.
package vjtag_readback_tx_pkg;

  localparam logic [1:0] IR_DATA   = 2'b11;
  localparam logic [1:0] IR_STATUS = 2'b01;

  localparam logic [7:0] STATUS_SIG = 8'hA5;
  localparam int STATUS_W = 32;
  localparam int SIG_LSB  = 24;
  localparam int OVF_BIT  = 7;
  localparam int UDF_BIT  = 6;
  localparam int CNT_LSB  = 0;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    MODE_BYPASS,
    MODE_STATUS,
    MODE_DATA
  } mode_e;

  // Every IR value that is neither DATA nor STATUS selects the bypass bit.
  function automatic mode_e ir_mode(input logic [1:0] ir);
    if (ir == IR_DATA)   return MODE_DATA;
    if (ir == IR_STATUS) return MODE_STATUS;
    return MODE_BYPASS;
  endfunction

  function automatic logic [STATUS_W-1:0] status_word(input logic ovf,
                                                      input logic udf,
                                                      input logic [CNT_W-1:0] cnt);
    logic [STATUS_W-1:0] w;
    w = '0;
    w[SIG_LSB +: 8]     = STATUS_SIG;
    w[OVF_BIT]          = ovf;
    w[UDF_BIT]          = udf;
    w[CNT_LSB +: CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/readback_fifo.sv
// Pending-word FIFO for host readback; power-of-two depth with wrapping pointers
// and an explicit occupancy count so full and empty are unambiguous.
module readback_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  // Refuse out-of-range requests here too, so count stays within 0..DEPTH.
  assign push_ok = push && (count != FULL_COUNT);
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vjtag_readback_tx.sv
// Virtual-JTAG readback transmitter: fabric pushes words into a FIFO, the host
// scans them out LSB-first through the DATA register or reads a status word.
module vjtag_readback_tx
  import vjtag_readback_tx_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   aclr_n,
  input  logic [1:0]             ir_in,
  input  logic                   vs_cdr,
  input  logic                   vs_sdr,
  input  logic                   vs_udr,
  input  logic                   tdi,
  output logic                   tdo,
  input  logic                   wr_valid,
  input  logic [DW-1:0]          wr_data,
  output logic                   wr_ready,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(DW + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [SW-1:0] SCAN_LEN   = SW'(DW);

  mode_e         mode;
  logic [DW-1:0] sr, head;
  logic [SW-1:0] shift_cnt;
  logic [1:0]    ir_prev;
  logic          bypass, cap_valid, ovf, udf;
  logic          push, pop, overflow, ir_changed, full_scan, status_clr, empty;

  assign mode       = ir_mode(ir_in);
  assign empty      = (fifo_count == '0);
  assign wr_ready   = (fifo_count != FULL_COUNT);
  assign push       = wr_valid && wr_ready;
  assign overflow   = wr_valid && !wr_ready;
  assign ir_changed = (ir_in != ir_prev);
  assign full_scan  = (shift_cnt == SCAN_LEN);
  // Only a complete, uninterrupted DATA scan consumes the captured head word.
  assign pop        = vs_udr && (mode == MODE_DATA) && cap_valid && full_scan && !ir_changed;
  assign status_clr = vs_udr && (mode == MODE_STATUS) && full_scan;
  assign tdo        = (mode == MODE_BYPASS) ? bypass : sr[0];

  readback_fifo #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (aclr_n),
    .push     (push),
    .push_data(wr_data),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count)
  );

  always_ff @(posedge CLK or negedge aclr_n) begin
    if (!aclr_n) begin
      sr        <= '0;
      bypass    <= 1'b0;
      shift_cnt <= '0;
    end else if (vs_cdr) begin
      shift_cnt <= '0;
      unique case (mode)
        MODE_DATA:   sr     <= empty ? '0 : head;
        MODE_STATUS: sr     <= DW'(status_word(ovf, udf, CNT_W'(fifo_count)));
        default:     bypass <= 1'b0;
      endcase
    end else if (vs_sdr) begin
      if (!full_scan) shift_cnt <= shift_cnt + SW'(1);
      if (mode == MODE_BYPASS) bypass <= tdi;
      else                     sr     <= {tdi, sr[DW-1:1]};
    end
  end

  always_ff @(posedge CLK or negedge aclr_n) begin
    if (!aclr_n) begin
      ir_prev   <= '0;
      cap_valid <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      ir_prev <= ir_in;

      if (vs_cdr)                   cap_valid <= (mode == MODE_DATA) && !empty;
      else if (pop || ir_changed)   cap_valid <= 1'b0;

      // A same-cycle overflow outranks the status-read clear.
      if (overflow)        ovf <= 1'b1;
      else if (status_clr) ovf <= 1'b0;

      if (vs_cdr && (mode == MODE_DATA) && empty) udf <= 1'b1;
      else if (status_clr)                        udf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vjtag_readback_tx.sv
// Randomised and directed bench for vjtag_readback_tx against a queue-based
// behavioural model, compared on every falling clock edge.
module tb_vjtag_readback_tx;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        aclr_n = 1'b0;
  logic [1:0]  ir_in = 2'b00;
  logic        vs_cdr = 1'b0, vs_sdr = 1'b0, vs_udr = 1'b0, tdi = 1'b0;
  logic        tdo;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic [2:0]  fifo_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 CLK = ~CLK;

  vjtag_readback_tx #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) dut (
    .CLK       (CLK),
    .aclr_n    (aclr_n),
    .ir_in     (ir_in),
    .vs_cdr    (vs_cdr),
    .vs_sdr    (vs_sdr),
    .vs_udr    (vs_udr),
    .tdi       (tdi),
    .tdo       (tdo),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .fifo_count(fifo_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: word queue, the scan register seen as a queue of bits
  // leaving at the front, and the sticky flags.
  logic [31:0] mq[$];
  bit          mbits[$];
  bit          m_byp, m_ovf, m_udf, m_pend;
  int          m_nbits;
  logic [1:0]  m_prev_ir;

  function automatic bit is_reg(input logic [1:0] ir);
    return (ir == 2'b11) || (ir == 2'b01);
  endfunction

  task automatic load_bits(input logic [31:0] w);
    mbits.delete();
    for (int i = 0; i < 32; i++) mbits.push_back(w[i]);
  endtask

  task automatic model_reset();
    mq.delete();
    load_bits(32'h0);
    m_byp = 0; m_ovf = 0; m_udf = 0; m_pend = 0; m_nbits = 0; m_prev_ir = 2'b00;
  endtask

  task automatic model_step();
    bit is_data, is_stat, full, do_push, ovf_evt, ir_chg, do_pop, stat_clr, udf_evt;
    logic [31:0] sw;
    is_data  = (ir_in == 2'b11);
    is_stat  = (ir_in == 2'b01);
    full     = (mq.size() >= DEPTH);
    do_push  = wr_valid && !full;
    ovf_evt  = wr_valid && full;
    ir_chg   = (ir_in != m_prev_ir);
    do_pop   = vs_udr && is_data && m_pend && (m_nbits == 32) && !ir_chg;
    stat_clr = vs_udr && is_stat && (m_nbits == 32);
    udf_evt  = 0;
    if (vs_cdr) begin
      m_nbits = 0;
      m_pend  = 0;
      if (is_data) begin
        if (mq.size() > 0) begin load_bits(mq[0]); m_pend = 1; end
        else begin load_bits(32'h0); udf_evt = 1; end
      end else if (is_stat) begin
        sw = 32'hA500_0000 | (32'(m_ovf) << 7) | (32'(m_udf) << 6) | 32'(mq.size());
        load_bits(sw);
      end else m_byp = 0;
    end else begin
      if (vs_sdr) begin
        if (is_data || is_stat) begin
          void'(mbits.pop_front());
          mbits.push_back(tdi);
        end else m_byp = tdi;
        if (m_nbits < 32) m_nbits++;
      end
      if (do_pop || ir_chg) m_pend = 0;
    end
    if (ovf_evt) m_ovf = 1; else if (stat_clr) m_ovf = 0;
    if (udf_evt) m_udf = 1; else if (stat_clr) m_udf = 0;
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(wr_data);
    m_prev_ir = ir_in;
  endtask

  initial model_reset();

  always @(posedge CLK or negedge aclr_n) begin
    if (!aclr_n) model_reset();
    else         model_step();
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("tdo",        32'(tdo),        32'(is_reg(ir_in) ? mbits[0] : m_byp));
      check("wr_ready",   32'(wr_ready),   32'(mq.size() < DEPTH));
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    end
  end

  // One clock of stimulus; tdo is sampled mid-cycle before the edge acts.
  task automatic cycle(input logic c, input logic s, input logic u, input logic ti,
                       input logic wv, input logic [31:0] wd, output logic t);
    vs_cdr = c; vs_sdr = s; vs_udr = u; tdi = ti; wr_valid = wv; wr_data = wd;
    @(negedge CLK);
    t = tdo;
    @(posedge CLK);
    #1;
    vs_cdr = 0; vs_sdr = 0; vs_udr = 0; tdi = 0; wr_valid = 0;
  endtask

  task automatic push(input logic [31:0] w);
    logic t;
    cycle(0, 0, 0, 0, 1, w, t);
  endtask

  task automatic scan(input logic [1:0] ir, input int nbits, input logic [31:0] din,
                      input bit rnd, input bit flip, input logic upd_wv,
                      input logic [31:0] upd_wd, output logic [31:0] dout);
    logic t;
    dout  = '0;
    ir_in = ir;
    cycle(1, 0, 0, 0, 0, 32'h0, t);
    for (int i = 0; i < nbits; i++) begin
      cycle(0, 1, 0, din[i % 32], rnd ? ($urandom_range(0, 3) == 0) : 1'b0, $urandom, t);
      if (i < 32) dout[i] = t;
    end
    if (flip) begin
      ir_in = ir ^ 2'b01;
      cycle(0, 0, 0, 0, 0, 32'h0, t);
      ir_in = ir;
    end
    cycle(0, 0, 1, 0, upd_wv, upd_wd, t);
  endtask

  task automatic ds(input logic [1:0] ir, input int n, output logic [31:0] d);
    scan(ir, n, $urandom, 0, 0, 0, 32'h0, d);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        t;
    int          op, len;
    logic [1:0]  rir;

    repeat (3) @(posedge CLK);
    #1;
    check("reset_count",    32'(fifo_count), 32'd0);
    check("reset_wr_ready", 32'(wr_ready),   32'd1);
    check("reset_tdo_byp",  32'(tdo),        32'd0);
    ir_in = 2'b11;
    #1;
    check("reset_tdo_data", 32'(tdo),        32'd0);
    aclr_n = 1'b1;
    chk_en = 1'b1;
    cycle(0, 0, 0, 0, 0, 32'h0, t);

    // Single word streamed out LSB-first, popped at update.
    push(32'hDEADBEEF);
    check("w1_count_pushed", 32'(fifo_count), 32'd1);
    ds(2'b11, 32, d);
    check("w1_stream", d, 32'hDEADBEEF);
    check("w1_count_popped", 32'(fifo_count), 32'd0);

    // Overflow on the fifth push; status shows ovf and count 4.
    for (int k = 0; k < 5; k++) begin
      push(32'h1000 + k);
      if (k == 3) check("ovf_ready_full", 32'(wr_ready), 32'd0);
    end
    check("ovf_count", 32'(fifo_count), 32'd4);
    ds(2'b01, 32, d);
    check("ovf_status", d, 32'hA5000084);
    ds(2'b01, 32, d);
    check("ovf_status_cleared", d, 32'hA5000004);
    for (int k = 0; k < 4; k++) begin
      ds(2'b11, 32, d);
      check("ovf_drain_order", d, 32'h1000 + k);
    end

    // Underflow on an empty DATA scan, cleared by a full STATUS scan.
    ds(2'b11, 32, d);
    check("udf_zeros", d, 32'h0);
    ds(2'b01, 32, d);
    check("udf_status", d, 32'hA5000040);
    ds(2'b01, 32, d);
    check("udf_status_cleared", d, 32'hA5000000);

    // A short scan does not pop; the word is re-offered.
    push(32'hAAAA5555);
    push(32'h12345678);
    ds(2'b11, 16, d);
    check("short_low_half", d & 32'h0000FFFF, 32'h00005555);
    check("short_no_pop", 32'(fifo_count), 32'd2);
    ds(2'b11, 32, d);
    check("short_reoffer", d, 32'hAAAA5555);
    check("short_then_pop", 32'(fifo_count), 32'd1);
    ds(2'b11, 32, d);
    check("short_second", d, 32'h12345678);

    // Full FIFO with push and pop in the same cycle: push refused.
    for (int k = 0; k < 4; k++) push(32'h2000 + k);
    check("samecyc_ready", 32'(wr_ready), 32'd0);
    scan(2'b11, 32, 32'h0, 0, 0, 1, 32'hBAD0BAD0, d);
    check("samecyc_head", d, 32'h2000);
    check("samecyc_count", 32'(fifo_count), 32'd3);
    ds(2'b01, 32, d);
    check("samecyc_status", d, 32'hA5000083);
    for (int k = 1; k < 4; k++) begin
      ds(2'b11, 32, d);
      check("samecyc_drain", d, 32'h2000 + k);
    end

    // An IR change between capture and update cancels the pop.
    push(32'hC0FFEE00);
    scan(2'b11, 32, 32'h0, 0, 1, 0, 32'h0, d);
    check("irchg_data", d, 32'hC0FFEE00);
    check("irchg_no_pop", 32'(fifo_count), 32'd1);
    ds(2'b11, 32, d);
    check("irchg_reoffer", d, 32'hC0FFEE00);

    // Bypass: one-cycle delay of tdi, starting from a captured 0.
    scan(2'b00, 8, 32'h000000B2, 0, 0, 0, 32'h0, d);
    check("bypass_stream", d, 32'h00000064);
    scan(2'b10, 8, 32'h0000004F, 0, 0, 0, 32'h0, d);
    check("bypass10_stream", d, 32'h0000009E);

    // Reset in the middle of a DATA scan.
    push(32'h11111111);
    ir_in = 2'b11;
    cycle(1, 0, 0, 0, 0, 32'h0, t);
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 1, 0, 32'h0, t);
    aclr_n = 1'b0;
    #1;
    check("midreset_count", 32'(fifo_count), 32'd0);
    check("midreset_ready", 32'(wr_ready),   32'd1);
    check("midreset_tdo",   32'(tdo),        32'd0);
    repeat (2) cycle(0, 0, 0, 0, 0, 32'h0, t);
    aclr_n = 1'b1;
    cycle(0, 0, 1, 0, 0, 32'h0, t);
    check("midreset_no_pop", 32'(fifo_count), 32'd0);
    push(32'h22222222);
    cycle(0, 0, 1, 0, 0, 32'h0, t);
    check("midreset_keep", 32'(fifo_count), 32'd1);
    ds(2'b01, 32, d);
    check("midreset_status", d, 32'hA5000001);
    ds(2'b11, 32, d);
    check("midreset_word", d, 32'h22222222);

    // Randomised traffic, checked by the per-cycle compare process.
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 9);
      if (op < 3) begin
        repeat ($urandom_range(1, 5)) push($urandom);
      end else begin
        rir = 2'($urandom);
        len = ($urandom_range(0, 1) == 1) ? 32 : $urandom_range(0, 40);
        scan(rir, len, $urandom, 1, $urandom_range(0, 5) == 0,
             1'($urandom_range(0, 1)), $urandom, d);
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
